// File: rtl/datastore_reader_pkg.sv
// Shared constants and types for the datastore read path.
// Used by datastore_reader and datastore_byte_sel.
package datastore_pkg;

  localparam int NUM_BYTES = 28;
  localparam int BYTE_W    = 8;
  localparam int IDX_W     = 5;
  localparam int STORE_W   = NUM_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } state_t;

  // Requests longer than the store collapse to a full-store read.
  function automatic logic [IDX_W-1:0] clamp_len(
    input logic [IDX_W-1:0] len
  );
    return (len > IDX_W'(NUM_BYTES)) ? IDX_W'(NUM_BYTES) : len;
  endfunction

endpackage

// File: rtl/datastore_byte_sel.sv
// Combinational NUM_BYTES:1 byte multiplexer over a packed store.
// Out-of-range indexes read as 0x00.
module datastore_byte_sel
  import datastore_pkg::*;
(
  input  logic [STORE_W-1:0] i_store,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [BYTE_W-1:0]  o_byte
);

  always_comb begin
    o_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (i_idx == IDX_W'(i)) begin
        o_byte = i_store[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/datastore_reader.sv
// Snapshots the byte store on start and streams it over valid/ready.
// Option: DATASTORE_READER_SKIP_NULL_EN skips 0x00 slots silently.
module datastore_reader
  import datastore_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [STORE_W-1:0] datastore_in,
  input  logic               start,
  input  logic [IDX_W-1:0]   length,
  input  logic               abort,
  input  logic               byte_ready,
  output logic [BYTE_W-1:0]  byte_out,
  output logic               byte_valid,
  output logic [IDX_W-1:0]   byte_index,
  output logic               busy,
  output logic               done
);

  state_t               r_state;
  logic [STORE_W-1:0]   r_snap;
  logic [IDX_W-1:0]     r_len;
  logic [IDX_W-1:0]     r_rd_idx;

  logic [BYTE_W-1:0]    w_byte;
  logic [IDX_W-1:0]     w_len_in;
  logic                 w_send;
  logic                 w_null;
  logic                 w_xfer;
  logic                 w_adv;
  logic                 w_last;

  datastore_byte_sel u_sel (
    .i_store (r_snap),
    .i_idx   (r_rd_idx),
    .o_byte  (w_byte)
  );

`ifdef DATASTORE_READER_SKIP_NULL_EN
  assign w_null = (w_byte == '0);
`else
  assign w_null = 1'b0;
`endif

  assign w_len_in = clamp_len(length);
  assign w_send   = (r_state == SEND);
  // A null slot is never presented; it just burns one cycle.
  assign w_xfer   = byte_valid & byte_ready;
  assign w_adv    = w_xfer | (w_send & w_null);
  assign w_last   = (r_rd_idx == (r_len - IDX_W'(1)));

  assign byte_valid = w_send & ~w_null;
  assign byte_out   = byte_valid ? w_byte : '0;
  assign byte_index = r_rd_idx;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_len    <= '0;
      r_rd_idx <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_snap   <= datastore_in;
            r_len    <= w_len_in;
            r_rd_idx <= '0;
            r_state  <= (w_len_in == '0) ? FIN : SEND;
          end
        end
        SEND: begin
          if (abort) begin
            r_state  <= IDLE;
            r_rd_idx <= '0;
          end else if (w_adv) begin
            if (w_last) begin
              r_state <= FIN;
            end else begin
              r_rd_idx <= r_rd_idx + IDX_W'(1);
            end
          end
        end
        FIN: begin
          r_state  <= IDLE;
          r_rd_idx <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datastore_reader.sv
// Randomized bench for datastore_reader against a queue-based model.
// Build with DATASTORE_READER_SKIP_NULL_EN to cover the skip option.
module tb_datastore_reader;
  import datastore_pkg::*;

`ifdef DATASTORE_READER_SKIP_NULL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [STORE_W-1:0] datastore_in;
  logic               start;
  logic [IDX_W-1:0]   length;
  logic               abort;
  logic               byte_ready;
  logic [BYTE_W-1:0]  byte_out;
  logic               byte_valid;
  logic [IDX_W-1:0]   byte_index;
  logic               busy;
  logic               done;

  datastore_reader dut (
    .clk          (clk),
    .reset        (reset),
    .datastore_in (datastore_in),
    .start        (start),
    .length       (length),
    .abort        (abort),
    .byte_ready   (byte_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .byte_index   (byte_index),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0=idle 1=streaming 2=finishing; queue of slots left.
  int         m_ph;
  int         m_q[$];
  logic [7:0] m_snap[NUM_BYTES];

  logic [7:0] log_b[$];
  int         log_i[$];
  int         done_cnt;
  int         done_cyc;
  int         cyc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic       ev;
    logic [7:0] eb;
    int         ei;
    ev = 1'b0;
    eb = 8'h00;
    ei = 0;
    if (m_ph == 1) begin
      ei = m_q[0];
      eb = m_snap[ei];
      ev = !(SKIP && eb == 8'h00);
    end
    chk("byte_valid", 32'(byte_valid), 32'(ev));
    chk("busy", 32'(busy), 32'(m_ph != 0));
    chk("done", 32'(done), 32'(m_ph == 2));
    if (ev) begin
      chk("byte_out", 32'(byte_out), 32'(eb));
      chk("byte_index", 32'(byte_index), 32'(ei));
    end
  endtask

  task automatic model_edge();
    int         len;
    logic [7:0] b;
    if (m_ph == 0) begin
      if (start) begin
        for (int i = 0; i < NUM_BYTES; i++)
          m_snap[i] = datastore_in[i*8 +: 8];
        len = (int'(length) > NUM_BYTES) ? NUM_BYTES : int'(length);
        m_q.delete();
        for (int i = 0; i < len; i++) m_q.push_back(i);
        m_ph = (len == 0) ? 2 : 1;
      end
    end else if (m_ph == 1) begin
      if (abort) begin
        m_ph = 0;
      end else begin
        b = m_snap[m_q[0]];
        if ((SKIP && b == 8'h00) || byte_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_ph = 2;
        end
      end
    end else begin
      m_ph = 0;
    end
  endtask

  // Called at a falling edge with inputs already set for the next rise.
  task automatic step();
    check_outputs();
    if (byte_valid && byte_ready && !abort) begin
      log_b.push_back(byte_out);
      log_i.push_back(int'(byte_index));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic begin_stream(input int len);
    log_b.delete();
    log_i.delete();
    done_cnt = 0;
    done_cyc = -1;
    cyc = 0;
    start = 1'b1;
    length = IDX_W'(len);
    step();
    start = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (m_ph != 0 && n < budget) begin
      step();
      n++;
    end
    chk("stream_end", 32'(m_ph), 32'd0);
    step();
  endtask

  task automatic set_slot(input int i, input logic [7:0] v);
    datastore_in[i*8 +: 8] = v;
  endtask

  initial begin
    reset = 1'b0;
    datastore_in = '0;
    start = 1'b0;
    length = '0;
    abort = 1'b0;
    byte_ready = 1'b0;
    m_ph = 0;
    cyc = 0;
    done_cnt = 0;
    done_cyc = -1;

    repeat (2) @(negedge clk);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_index", 32'(byte_index), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    step();

    // Five bytes, ready held high.
    for (int i = 0; i < 5; i++) set_slot(i, 8'(8'h41 + i));
    byte_ready = 1'b1;
    begin_stream(5);
    run_idle(20);
    chk("t1_count", 32'(log_b.size()), 32'd5);
    chk("t1_b0", 32'(log_b[0]), 32'h41);
    chk("t1_b4", 32'(log_b[4]), 32'h45);
    chk("t1_i4", 32'(log_i[4]), 32'd4);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_cyc", 32'(done_cyc), 32'd6);

    // Backpressure: ready 1,0,0,1,1.
    byte_ready = 1'b1;
    begin_stream(3);
    byte_ready = 1'b1; step();
    byte_ready = 1'b0; step(); step();
    byte_ready = 1'b1;
    run_idle(20);
    chk("t2_count", 32'(log_b.size()), 32'd3);
    chk("t2_b1", 32'(log_b[1]), 32'h42);
    chk("t2_b2", 32'(log_b[2]), 32'h43);
    chk("t2_done_cyc", 32'(done_cyc), 32'd6);

    // Oversized length clamps to the full store.
    for (int i = 0; i < NUM_BYTES; i++) set_slot(i, 8'h5A);
    begin_stream(31);
    run_idle(40);
    chk("t3_count", 32'(log_b.size()), 32'd28);
    chk("t3_last_idx", 32'(log_i[27]), 32'd27);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Zero length: only done.
    begin_stream(0);
    run_idle(5);
    chk("t4_count", 32'(log_b.size()), 32'd0);
    chk("t4_done_cyc", 32'(done_cyc), 32'd1);

    // Live-store write and restart request during a stream.
    datastore_in = '0;
    for (int i = 0; i < 5; i++) set_slot(i, 8'(8'h41 + i));
    begin_stream(5);
    step();
    set_slot(2, 8'hFF);
    start = 1'b1;
    step();
    start = 1'b0;
    run_idle(20);
    repeat (3) step();
    chk("t5_slot2", 32'(log_b[2]), 32'h43);
    chk("t5_count", 32'(log_b.size()), 32'd5);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Abort while index 2 is offered with ready high.
    set_slot(2, 8'h43);
    begin_stream(5);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_valid", 32'(byte_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (3) step();
    chk("t6_count", 32'(log_b.size()), 32'd2);
    chk("t6_done_cnt", 32'(done_cnt), 32'd0);

    // Asynchronous reset mid-stream.
    byte_ready = 1'b0;
    begin_stream(5);
    step();
    reset = 1'b0;
    #1;
    chk("t7_byte_out", 32'(byte_out), 32'd0);
    chk("t7_valid", 32'(byte_valid), 32'd0);
    chk("t7_index", 32'(byte_index), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    m_ph = 0;
    m_q.delete();
    @(negedge clk);
    reset = 1'b1;
    step();

    // Null slot handling depends on the build option.
    datastore_in = '0;
    set_slot(0, 8'h41);
    set_slot(2, 8'h43);
    byte_ready = 1'b1;
    begin_stream(3);
    run_idle(10);
    chk("t8_count", 32'(log_b.size()), SKIP ? 32'd2 : 32'd3);
    chk("t8_b1", 32'(log_b[1]), SKIP ? 32'h43 : 32'h00);
    chk("t8_i1", 32'(log_i[1]), SKIP ? 32'd2 : 32'd1);
    chk("t8_done_cnt", 32'(done_cnt), 32'd1);

    // Randomized streams.
    for (int it = 0; it < 40; it++) begin
      int n;
      for (int i = 0; i < NUM_BYTES; i++)
        set_slot(i, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      byte_ready = 1'($urandom_range(0, 1));
      begin_stream(int'($urandom_range(0, 31)));
      n = 0;
      while (m_ph != 0 && n < 80) begin
        byte_ready = ($urandom_range(0, 2) != 0);
        abort = ($urandom_range(0, 24) == 0);
        start = ($urandom_range(0, 9) == 0);
        length = IDX_W'($urandom_range(0, 31));
        if ($urandom_range(0, 4) == 0)
          set_slot(int'($urandom_range(0, NUM_BYTES - 1)), 8'($urandom));
        step();
        n++;
      end
      abort = 1'b0;
      start = 1'b0;
      run_idle(80);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/datastore_reader.md
Name: datastore_reader

Overview:
- Read-side counterpart to the PS/2 byte datastore.
- Captures a snapshot of the 224-bit store (28 bytes) on a start request.
- Streams the bytes out one per handshake, in index order, to the downstream consumer (cipher core or display path) using a valid/ready interface.
- Signals completion with a one-cycle done pulse; a snapshot isolates the stream from concurrent keyboard writes.

Parameters:
- NUM_BYTES, 28, number of byte slots in the store.
- BYTE_W, 8, width of one slot.
- IDX_W, 5, width of the slot index and the length field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
- datastore_in  input  NUM_BYTES*BYTE_W  live store contents; slot i occupies bits [8i+7:8i].
- start  input  1  request to stream; sampled only in IDLE.
- length  input  IDX_W  number of bytes to send, sampled with start.
- abort  input  1  cancels an active stream.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- byte_out  output  BYTE_W  current byte.
- byte_valid  output  1  byte_out/byte_index are valid.
- byte_index  output  IDX_W  slot number of byte_out.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse after the last transfer.

Behaviour:
- Reset values, all outputs 0: byte_out=0x00, byte_valid=0, byte_index=0, busy=0, done=0. Internal state: IDLE, snapshot cleared, counters 0.
- States are IDLE, SEND and FIN.
- IDLE:
  - On start=1, copy datastore_in into the snapshot register and latch len_q.
  - len_q is length clamped to NUM_BYTES (values 29..31 become 28).
  - If len_q=0, go directly to FIN. Otherwise go to SEND with rd_idx=0.
- SEND:
  - byte_valid=1, byte_out=snapshot slot rd_idx, byte_index=rd_idx.
  - Transfer happens when byte_valid&byte_ready. On transfer, rd_idx increments; if rd_idx=len_q-1, go to FIN.
  - While byte_valid=1 and byte_ready=0, byte_out and byte_index hold stable. byte_valid never drops without a transfer except on abort or reset.
  - byte_valid depends only on state; it is never combinationally dependent on byte_ready.
- FIN:
  - done=1 for exactly one cycle, byte_valid=0, then return to IDLE.
  - busy stays 1 during FIN.
- Latency:
  - start to first byte_valid is 1 cycle.
  - Back-to-back transfers are possible every cycle when byte_ready is held high.
  - A 28-byte stream with ready held high takes 28 SEND cycles plus 1 FIN cycle.
- start while busy is ignored; no queuing.
- abort=1 in SEND:
  - Next state is IDLE, byte_valid=0, no done pulse.
  - abort takes priority over a simultaneous transfer; that byte counts as not sent.
  - abort in IDLE or FIN has no effect.
- Changes to datastore_in after start do not affect the stream.
- rd_idx never exceeds NUM_BYTES-1, and there is no wrap-around.
- Asserting reset mid-stream immediately forces the reset values, including byte_valid=0.

Optional Feature:
- Macro: DATASTORE_READER_SKIP_NULL_EN.
- Defined:
  - Slots whose snapshot byte is 0x00 are skipped without being presented; byte_index still reports the true slot number.
  - Skipping advances one slot per cycle with byte_valid=0.
  - If the final counted slot (len_q-1) is null, go to FIN after skipping it.
  - A stream of all-null bytes produces only done.
- Undefined: every slot 0..len_q-1 is presented, including 0x00.

Decomposition:
- Package datastore_pkg holds:
  - constants NUM_BYTES, BYTE_W, IDX_W, STORE_W=NUM_BYTES*BYTE_W;
  - state enum {IDLE, SEND, FIN}.
- One sub-module, datastore_byte_sel: combinational NUM_BYTES:1 byte multiplexer from snapshot and index to byte.
  - The same datastore_byte_sel module is also reusable by the display path.
- FSM, counters and snapshot stay in datastore_reader.

Test Plan:
- Fill slots 0..4 with 0x41,0x42,0x43,0x44,0x45; start with length=5 and byte_ready=1 held -> bytes 0x41..0x45 on 5 consecutive cycles, byte_index 0..4, done pulses once on the cycle after index 4.
- length=3, byte_ready toggling 1,0,0,1,1 -> byte_out/byte_index held stable during the ready=0 cycles; exactly 3 transfers (0x41,0x42,0x43), then done.
- length=31 with all slots 0x5A -> exactly 28 transfers with indexes 0..27, then done. Separately, length=0 -> no byte_valid, done on the cycle after start.
- Start stream, then overwrite datastore_in slot 2 with 0xFF after start -> the slot-2 transfer still reports 0x43. A start pulse while busy -> ignored, no second done.
- abort asserted with byte_ready=1 during index 2 -> byte_valid=0 next cycle, busy=0, no done. Reset pulled low mid-stream -> all outputs 0 immediately.
- With DATASTORE_READER_SKIP_NULL_EN and slots {0x41,0x00,0x43}, length=3 -> transfers 0x41 at idx0 and 0x43 at idx2 only, then done. Without the macro -> three transfers, including 0x00 at idx1.
